// File: rtl/lcd_instr_sched_if.sv
// Requester (A, B) and PHY instruction handshakes of the HD44780 instruction scheduler.
interface lcd_instr_sched_if #(
    parameter int unsigned INSTR_WIDTH = 10
);
    logic [INSTR_WIDTH-1:0] a_instr_i;
    logic                   a_valid_i;
    logic                   a_ready_o;
    logic [INSTR_WIDTH-1:0] b_instr_i;
    logic                   b_valid_i;
    logic                   b_ready_o;
    logic [INSTR_WIDTH-1:0] instr_o;
    logic                   valid_o;
    logic                   ready_i;

    // Scheduler side
    modport slave (
        input  a_instr_i, a_valid_i, b_instr_i, b_valid_i, ready_i,
        output a_ready_o, b_ready_o, instr_o, valid_o
    );

    // Requesters plus PHY side
    modport master (
        output a_instr_i, a_valid_i, b_instr_i, b_valid_i, ready_i,
        input  a_ready_o, b_ready_o, instr_o, valid_o
    );
endinterface

// File: rtl/lcd_instr_sched.sv
// HD44780 instruction scheduler: power-on init sequence, round-robin sharing of the
// PHY between requesters A and B, and command-dependent execution waits.
module lcd_instr_sched #(
    parameter int unsigned INSTR_WIDTH    = 10,
    parameter int unsigned DELAY_WIDTH    = 21,
    parameter int unsigned POWERUP_CYCLES = 1500000,
    parameter int unsigned CMD_WAIT       = 4000,
    parameter int unsigned CLR_WAIT       = 153000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    lcd_instr_sched_if.slave  bus,
    output logic              init_done_o,
    output logic              busy_o
);

    localparam int unsigned STEP_W     = 3;
    localparam int unsigned INIT_STEPS = 5;

    typedef enum logic [2:0] {
        S_OFF,
        S_PWRUP,
        S_INIT_ISSUE,
        S_INIT_WAIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_e;

    state_e                  state_q, state_d;
    logic [DELAY_WIDTH-1:0]  cnt_q, cnt_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic                    last_grant_q, last_grant_d;   // 1: B was granted last
    logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
    logic                    valid_q, valid_d;
    logic                    init_done_q, init_done_d;
    logic                    busy_q, busy_d;
    logic                    grant_a, grant_b;

    // Fixed HD44780 power-on sequence: function set x2, display on, clear, entry mode
    function automatic logic [INSTR_WIDTH-1:0] init_rom(input logic [STEP_W-1:0] idx);
        logic [INSTR_WIDTH-1:0] word;
        case (idx)
            3'd0, 3'd1: word = INSTR_WIDTH'(10'h038);
            3'd2:       word = INSTR_WIDTH'(10'h00C);
            3'd3:       word = INSTR_WIDTH'(10'h001);
            default:    word = INSTR_WIDTH'(10'h006);
        endcase
        return word;
    endfunction

    // Clear display and return home are the slow commands; all else uses the short wait
    function automatic logic [DELAY_WIDTH-1:0] wait_load(input logic [INSTR_WIDTH-1:0] instr);
        logic [DELAY_WIDTH-1:0] load;
        if ((instr[INSTR_WIDTH-1:2] == '0) && (instr[1:0] != 2'b00)) begin
            load = DELAY_WIDTH'(CLR_WAIT - 1);
        end else begin
            load = DELAY_WIDTH'(CMD_WAIT - 1);
        end
        return load;
    endfunction

    // Round-robin arbitration, evaluated only while idle and fully enabled
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if ((state_q == S_IDLE) && enable_i && init_done_q) begin
            if (bus.a_valid_i && bus.b_valid_i) begin
                grant_a = last_grant_q;
                grant_b = !last_grant_q;
            end else begin
                grant_a = bus.a_valid_i;
                grant_b = bus.b_valid_i;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        step_d       = step_q;
        last_grant_d = last_grant_q;
        instr_d      = instr_q;

        unique case (state_q)
            S_OFF: begin
                if (enable_i) begin
                    state_d = S_PWRUP;
                    cnt_d   = DELAY_WIDTH'(POWERUP_CYCLES - 1);
                end
            end
            S_PWRUP: begin
                if (!enable_i) begin
                    state_d = S_OFF;
                end else if (cnt_q == '0) begin
                    state_d = S_INIT_ISSUE;
                    step_d  = '0;
                    instr_d = init_rom('0);
                end else begin
                    cnt_d = cnt_q - DELAY_WIDTH'(1);
                end
            end
            S_INIT_ISSUE: begin
                // A pending handshake always completes, even when disabled
                if (bus.ready_i) begin
                    if (!enable_i) begin
                        state_d = S_OFF;
                    end else begin
                        state_d = S_INIT_WAIT;
                        cnt_d   = wait_load(instr_q);
                    end
                end
            end
            S_INIT_WAIT: begin
                if (!enable_i) begin
                    state_d = S_OFF;
                end else if (cnt_q == '0) begin
                    if (step_q == STEP_W'(INIT_STEPS - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_INIT_ISSUE;
                        step_d  = step_q + STEP_W'(1);
                        instr_d = init_rom(step_q + STEP_W'(1));
                    end
                end else begin
                    cnt_d = cnt_q - DELAY_WIDTH'(1);
                end
            end
            S_IDLE: begin
                if (!enable_i) begin
                    state_d = S_OFF;
                end else if (grant_a) begin
                    state_d      = S_ISSUE;
                    instr_d      = bus.a_instr_i;
                    last_grant_d = 1'b0;
                end else if (grant_b) begin
                    state_d      = S_ISSUE;
                    instr_d      = bus.b_instr_i;
                    last_grant_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (bus.ready_i) begin
                    if (!enable_i) begin
                        state_d = S_OFF;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = wait_load(instr_q);
                    end
                end
            end
            S_WAIT: begin
                if (!enable_i) begin
                    state_d = S_OFF;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - DELAY_WIDTH'(1);
                end
            end
            default: begin
                state_d = S_OFF;
            end
        endcase

        // Status flags are registered copies of what the next state implies
        valid_d     = (state_d == S_INIT_ISSUE) || (state_d == S_ISSUE);
        busy_d      = !((state_d == S_OFF) || (state_d == S_IDLE));
        init_done_d = (state_d == S_IDLE) || (state_d == S_ISSUE) || (state_d == S_WAIT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_OFF;
            cnt_q        <= '0;
            step_q       <= '0;
            last_grant_q <= 1'b1;
            instr_q      <= '0;
            valid_q      <= 1'b0;
            init_done_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            step_q       <= step_d;
            last_grant_q <= last_grant_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
            init_done_q  <= init_done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.a_ready_o = grant_a;
    assign bus.b_ready_o = grant_b;
    assign bus.instr_o   = instr_q;
    assign bus.valid_o   = valid_q;
    assign init_done_o   = init_done_q;
    assign busy_o        = busy_q;

endmodule
